// File: rtl/aes_pkg.sv
// Shared AES byte-level definitions: S-box table, state byte indexing, FSM states.
package aes_pkg;

    localparam int unsigned NB = 4;

    // FSM states of the iterative SubBytes/ShiftRows stage
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ssr_state_t;

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup: entry x lives at bits 2047-8x down to 2040-8x
    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    // Column-major byte index of (row, col)
    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
        return {c, r};
    endfunction

    // Destination of byte (r, c) after ShiftRows: column rotates left by r
    function automatic logic [3:0] shift_dst(input logic [1:0] r, input logic [1:0] c);
        return idx(r, 2'(c - r));
    endfunction

    // MSB bit position of byte i in a 128-bit state (byte 0 is the top byte)
    function automatic logic [6:0] byte_msb(input logic [3:0] i);
        return {~i, 3'b111};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    assign byte_out = sbox_lookup(byte_in);

endmodule

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: LANES bytes per cycle, ShiftRows folded
// into the write address of the working register.
module sub_shift_rows
    import aes_pkg::*;
#(
    parameter int unsigned DATA_LEN = 128,
    parameter int unsigned LANES    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [DATA_LEN-1:0] data_out
);

    localparam int unsigned BLOCK_CYCLES = 16 / LANES;
    localparam int unsigned CNT_W        = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_CYCLES - 1);

    ssr_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_LEN-1:0] in_reg, in_n;
    logic [DATA_LEN-1:0] work_reg, work_n;
    logic [DATA_LEN-1:0] data_out_n;
    logic                valid_out_n;

    logic [3:0] src_idx  [LANES];
    logic [3:0] dst_idx  [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Per-lane source byte for this count and its post-ShiftRows destination
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            src_idx[l] = 4'(32'(LANES) * 32'(cnt) + l);
            dst_idx[l] = shift_dst(src_idx[l][1:0], src_idx[l][3:2]);
            lane_in[l] = in_reg[byte_msb(src_idx[l]) -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .byte_in  (lane_in[g]),
            .byte_out (lane_out[g])
        );
    end

    // Next-state, handshake and datapath update
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        in_n        = in_reg;
        work_n      = work_reg;
        data_out_n  = data_out;
        valid_out_n = valid_out;
        ready_out   = 1'b0;

        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    in_n    = data_in;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_n[byte_msb(dst_idx[l]) -: 8] = lane_out[l];
                end
                cnt_n = CNT_W'(cnt + 1'b1);
                if (cnt == LAST_CNT) begin
                    cnt_n       = '0;
                    state_n     = DONE;
                    valid_out_n = 1'b1;
                    data_out_n  = work_n;
                end
            end
            DONE: begin
                ready_out = ready_in;
                if (ready_in) begin
                    valid_out_n = 1'b0;
                    if (valid_in) begin
                        in_n    = data_in;
                        cnt_n   = '0;
                        state_n = BUSY;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            in_reg    <= '0;
            work_reg  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            in_reg    <= in_n;
            work_reg  <= work_n;
            data_out  <= data_out_n;
            valid_out <= valid_out_n;
        end
    end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Directed bench for sub_shift_rows (LANES=4) plus a LANES=1/2/16 sweep.
module tb_sub_shift_rows;

    localparam logic [127:0] ZERO     = 128'h0;
    localparam logic [127:0] ALL63    = {16{8'h63}};
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] INC_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] INC_OUT  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] JUNK     = {16{8'hff}};

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in, ready_in;
    logic         ready_out, valid_out;
    logic [127:0] data_in, data_out;

    logic         sw_valid_in, sw_ready_in;
    logic [127:0] sw_data_in;
    logic         sw_ready_out [3];
    logic         sw_vout      [3];
    logic [127:0] sw_dout      [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_shift_rows #(.DATA_LEN(128), .LANES(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .data_in(data_in), .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out)
    );

    sub_shift_rows #(.DATA_LEN(128), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .valid_in(sw_valid_in), .ready_out(sw_ready_out[0]),
        .data_in(sw_data_in), .valid_out(sw_vout[0]), .ready_in(sw_ready_in), .data_out(sw_dout[0])
    );

    sub_shift_rows #(.DATA_LEN(128), .LANES(2)) dut_l2 (
        .clk(clk), .reset(reset), .valid_in(sw_valid_in), .ready_out(sw_ready_out[1]),
        .data_in(sw_data_in), .valid_out(sw_vout[1]), .ready_in(sw_ready_in), .data_out(sw_dout[1])
    );

    sub_shift_rows #(.DATA_LEN(128), .LANES(16)) dut_l16 (
        .clk(clk), .reset(reset), .valid_in(sw_valid_in), .ready_out(sw_ready_out[2]),
        .data_in(sw_data_in), .valid_out(sw_vout[2]), .ready_in(sw_ready_in), .data_out(sw_dout[2])
    );

    // Present one state for a single edge; returns #1 after the accept edge
    task automatic send(input logic [127:0] d);
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = ZERO;
    endtask

    // Count edges until valid_out rises, bounded
    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid_in = 1'b0; ready_in = 1'b0; data_in = ZERO;
        sw_valid_in = 1'b0; sw_ready_in = 1'b0; sw_data_in = ZERO;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++;
        if (data_out !== ZERO) begin errors++; $display("FAIL reset_data_out: got %h want %h", data_out, ZERO); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
    endtask

    task automatic test_zero_block;
        int lat; bit ok;
        ready_in = 1'b1;
        send(ZERO);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", lat); end
        checks++;
        if (data_out !== ALL63) begin errors++; $display("FAIL zero_data: got %h want %h", data_out, ALL63); end
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL zero_valid_drop: got %b want 0", valid_out); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL zero_idle_ready: got %b want 1", ready_out); end
    endtask

    task automatic test_fips;
        int lat; bit ok;
        ready_in = 1'b1;
        send(FIPS_IN);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL fips_latency: got %0d want 4", lat); end
        checks++;
        if (data_out !== FIPS_OUT) begin errors++; $display("FAIL fips_data: got %h want %h", data_out, FIPS_OUT); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat; bit ok;
        ready_in = 1'b0;
        send(FIPS_IN);
        wait_valid(lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_first_valid: got timeout want valid_out"); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (data_out !== FIPS_OUT) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, data_out, FIPS_OUT); end
            checks++;
            if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, valid_out); end
            checks++;
            if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, ready_out); end
        end
        valid_in = 1'b1;
        data_in  = INC_IN;
        ready_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ready_out); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = ZERO;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_handoff_valid: got %b want 0", valid_out); end
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_handoff_busy: got %b want 0", ready_out); end
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL bp_second_latency: got %0d want 4", lat); end
        checks++;
        if (data_out !== INC_OUT) begin errors++; $display("FAIL bp_second_data: got %h want %h", data_out, INC_OUT); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore;
        int lat; bit ok;
        ready_in = 1'b1;
        send(FIPS_IN);
        valid_in = 1'b1;
        data_in  = JUNK;
        @(posedge clk); #1;
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", ready_out); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = ZERO;
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 2) begin errors++; $display("FAIL busy_latency: got %0d want 2", lat); end
        checks++;
        if (data_out !== FIPS_OUT) begin errors++; $display("FAIL busy_data: got %h want %h", data_out, FIPS_OUT); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy;
        int lat; bit ok;
        ready_in = 1'b1;
        send(ZERO);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL rstbusy_valid: got %b want 0", valid_out); end
        checks++;
        if (data_out !== ZERO) begin errors++; $display("FAIL rstbusy_data: got %h want %h", data_out, ZERO); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL rstbusy_ready: got %b want 1", ready_out); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send(ZERO);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL rstbusy_latency: got %0d want 4", lat); end
        checks++;
        if (data_out !== ALL63) begin errors++; $display("FAIL rstbusy_data_after: got %h want %h", data_out, ALL63); end
        @(posedge clk); #1;
    endtask

    task automatic test_lanes_sweep;
        int           lat [3];
        logic [127:0] got [3];
        int           want_lat [3];
        want_lat[0] = 16; want_lat[1] = 8; want_lat[2] = 1;
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            got[k] = ZERO;
        end
        sw_ready_in = 1'b1;
        sw_valid_in = 1'b1;
        sw_data_in  = FIPS_IN;
        @(posedge clk); #1;
        sw_valid_in = 1'b0;
        sw_data_in  = ZERO;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (sw_vout[k] && lat[k] == 0) begin
                    lat[k] = i;
                    got[k] = sw_dout[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat[k] != want_lat[k]) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", k, lat[k], want_lat[k]); end
            checks++;
            if (got[k] !== FIPS_OUT) begin errors++; $display("FAIL sweep_data[%0d]: got %h want %h", k, got[k], FIPS_OUT); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_fips();
        test_backpressure();
        test_busy_ignore();
        test_reset_busy();
        test_lanes_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
